// File: rtl/ma_mem_access_unit.sv
// Memory-access stage: one req/ack transaction per load or store on a variable-latency
// data-memory port, with byte enables, store lane replication and load alignment/extension.
module ma_mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func_3,
   input  logic [31:0] ALU_out,
   input  logic [31:0] DATA_2,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   output logic        busywait,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        mem_error
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;

   logic        op;
   logic        is_store;
   logic        illegal;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext;

   // A simultaneous read and write is handled as a store.
   assign op       = mem_read | mem_write;
   assign is_store = mem_write;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      illegal = 1'b1;
      case (func_3)
         3'b000:  illegal = 1'b0;
         3'b100:  illegal = is_store;
         3'b001:  illegal = ALU_out[0];
         3'b101:  illegal = is_store | ALU_out[0];
         3'b010:  illegal = (ALU_out[1:0] != 2'b00);
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = DATA_2;
      case (func_3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << ALU_out[1:0];
            st_wdata = {4{DATA_2[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << {ALU_out[1], 1'b0};
            st_wdata = {2{DATA_2[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = DATA_2;
         end
      endcase
   end

   // Load extraction uses the offset and funct3 latched at request time.
   always_comb begin
      byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ld_ext   = dmem_rdata;
      case (f3_q)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_ext = {24'b0, byte_sel};
         3'b101:  ld_ext = {16'b0, half_sel};
         default: ld_ext = dmem_rdata;
      endcase
   end

   assign misaligned = RESET & (state == IDLE) & op & illegal;
   assign busywait   = RESET & (((state == IDLE) & op & ~illegal) | (state == WAIT));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: every register here, load_data included, is cleared by reset; none is a memory array.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         counter    <= '0;
         off_q      <= 2'b00;
         f3_q       <= 3'b000;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'h0;
         dmem_be    <= 4'h0;
         dmem_wdata <= 32'h0;
         load_data  <= 32'h0;
         mem_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op && !illegal) begin
                  state      <= WAIT;
                  counter    <= '0;
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= {ALU_out[31:2], 2'b00};
                  dmem_be    <= is_store ? st_be : 4'b1111;
                  dmem_wdata <= is_store ? st_wdata : 32'h0;
                  off_q      <= ALU_out[1:0];
                  f3_q       <= func_3;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  state    <= RESP;
                  dmem_req <= 1'b0;
                  if (!dmem_we) load_data <= ld_ext;
               end else if (counter == LAST_CNT) begin
                  state     <= RESP;
                  dmem_req  <= 1'b0;
                  mem_error <= 1'b1;
                  if (!dmem_we) load_data <= 32'h0;
               end else begin
                  counter <= counter + CNT_W'(1);
               end
            end
            RESP: begin
               // The pipeline advances on this edge; the same instruction is never reissued.
               state     <= IDLE;
               mem_error <= 1'b0;
               counter   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
